// File: rtl/cache_rw_fill.sv
// Line-refill sequencer: clears a line's DRE flags, bursts the line in from memory, sets flags per word pair.
// Optional CACHE_FILL_CRITICAL_WORD_FIRST_EN starts the burst at the missed word and wraps.
module cache_rw_fill #(
    parameter int ADDR_WIDTH = 8,
    parameter int LINE_WORDS = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    req_valid,
    output logic                                    req_ready,
    input  logic [ADDR_WIDTH-$clog2(LINE_WORDS)-1:0] req_lineAddr,
    input  logic [1:0]                              req_channel,
    input  logic [$clog2(LINE_WORDS)-1:0]           req_wordOffset,
    output logic                                    mem_readRequest,
    input  logic                                    mem_readAccept,
    output logic [ADDR_WIDTH-1:0]                   mem_address,
    input  logic                                    mem_readDataValid,
    input  logic [31:0]                             mem_readData,
    output logic [ADDR_WIDTH-1:0]                   dat_writeAddress,
    output logic [1:0]                              dat_writeChannel,
    output logic [31:0]                             dat_writeData,
    output logic                                    dat_writeEnable,
    output logic [ADDR_WIDTH-1:0]                   dre_writeAddress,
    output logic [1:0]                              dre_writeChannel,
    output logic [7:0]                              dre_writeRe,
    output logic                                    dre_writeEnable,
    output logic                                    busy,
    output logic                                    done
);
    localparam int WB = $clog2(LINE_WORDS);
    localparam int LW = ADDR_WIDTH - WB;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] REQ   = 3'd2;
    localparam logic [2:0] FILL  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]    state;
    logic [LW-1:0] lineAddr;
    logic [1:0]    channel;
    logic [WB-1:0] startWord;
    logic [WB-1:0] pairCnt;
    logic [WB-1:0] beatCnt;
    logic [WB-1:0] wordIdx;
    logic [WB-1:0] pairWord;
    logic          fillBeat;
    logic          pairDone;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    logic [LINE_WORDS-1:0] rcvMask;

    // The arriving word completes its pair only if its partner is already in.
    assign pairDone = rcvMask[wordIdx ^ WB'(1)];
`else
    logic unusedOffset;

    assign unusedOffset = ^req_wordOffset;
    assign startWord    = '0;
    assign pairDone     = beatCnt[0];
`endif

    assign fillBeat = (state == FILL) && mem_readDataValid;
    assign pairWord = WB'(pairCnt << 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lineAddr <= '0;
            channel  <= '0;
            pairCnt  <= '0;
            beatCnt  <= '0;
            wordIdx  <= '0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
            startWord <= '0;
            rcvMask   <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    lineAddr <= req_lineAddr;
                    channel  <= req_channel;
                    pairCnt  <= '0;
                    beatCnt  <= '0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
                    startWord <= req_wordOffset;
                    wordIdx   <= req_wordOffset;
                    rcvMask   <= '0;
`else
                    wordIdx <= '0;
`endif
                    state <= CLEAR;
                end
                CLEAR: begin
                    pairCnt <= pairCnt + 1'b1;
                    if (pairCnt == WB'(LINE_WORDS / 2 - 1)) state <= REQ;
                end
                REQ: if (mem_readAccept) state <= FILL;
                FILL: if (fillBeat) begin
                    wordIdx <= wordIdx + 1'b1;
                    beatCnt <= beatCnt + 1'b1;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
                    rcvMask[wordIdx] <= 1'b1;
`endif
                    if (beatCnt == WB'(LINE_WORDS - 1)) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready       = (state == IDLE);
    assign busy            = (state != IDLE);
    assign done            = (state == DONE);
    assign mem_readRequest = (state == REQ);
    assign mem_address     = {lineAddr, startWord};

    assign dat_writeEnable  = fillBeat;
    assign dat_writeAddress = {lineAddr, wordIdx};
    assign dat_writeChannel = channel;
    assign dat_writeData    = mem_readData;

    always_comb begin
        dre_writeEnable  = 1'b0;
        dre_writeRe      = 8'h00;
        dre_writeAddress = {lineAddr, pairWord};
        dre_writeChannel = channel;
        if (state == CLEAR) begin
            dre_writeEnable = 1'b1;
        end else if (fillBeat && pairDone) begin
            dre_writeEnable  = 1'b1;
            dre_writeRe      = 8'hFF;
            dre_writeAddress = {lineAddr, wordIdx & ~WB'(1)};
        end
    end
endmodule

// File: tb/tb_cache_rw_fill.sv
// Directed bench for cache_rw_fill: per-cycle vector table plus hand sequences for
// delayed accept / gapped beats, mid-fill reset and (if enabled) critical-word-first order.
module tb_cache_rw_fill;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_lineAddr;
    logic [1:0]  req_channel;
    logic [2:0]  req_wordOffset;
    logic        mem_readRequest;
    logic        mem_readAccept;
    logic [7:0]  mem_address;
    logic        mem_readDataValid;
    logic [31:0] mem_readData;
    logic [7:0]  dat_writeAddress;
    logic [1:0]  dat_writeChannel;
    logic [31:0] dat_writeData;
    logic        dat_writeEnable;
    logic [7:0]  dre_writeAddress;
    logic [1:0]  dre_writeChannel;
    logic [7:0]  dre_writeRe;
    logic        dre_writeEnable;
    logic        busy;
    logic        done;

    cache_rw_fill #(.ADDR_WIDTH(8), .LINE_WORDS(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_lineAddr(req_lineAddr),
        .req_channel(req_channel), .req_wordOffset(req_wordOffset),
        .mem_readRequest(mem_readRequest), .mem_readAccept(mem_readAccept), .mem_address(mem_address),
        .mem_readDataValid(mem_readDataValid), .mem_readData(mem_readData),
        .dat_writeAddress(dat_writeAddress), .dat_writeChannel(dat_writeChannel),
        .dat_writeData(dat_writeData), .dat_writeEnable(dat_writeEnable),
        .dre_writeAddress(dre_writeAddress), .dre_writeChannel(dre_writeChannel),
        .dre_writeRe(dre_writeRe), .dre_writeEnable(dre_writeEnable),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        reqValid;
        logic        accept;
        logic        rdValid;
        logic [31:0] rdData;
        logic [3:0]  flags;     // {req_ready, busy, done, mem_readRequest}
        logic        datWe;
        logic [7:0]  datAddr;
        logic [31:0] datData;
        logic        dreWe;
        logic [7:0]  dreAddr;
        logic [7:0]  dreRe;
    } vec_t;

    vec_t        vt[$];
    int          nVec = 0;
    int          nErr = 0;
    logic [23:0] dreQ[$];       // {dat writes seen so far, address, flag byte}
    logic [39:0] datQ[$];       // {address, data}
    int          reqCycles;
    int          doneCnt;

    function automatic vec_t mk(input logic rv, input logic acc, input logic dv, input logic [31:0] d,
                                input logic [3:0] fl, input logic dwe, input logic [7:0] da,
                                input logic [31:0] dd, input logic rwe, input logic [7:0] ra,
                                input logic [7:0] re);
        vec_t v;
        v.reqValid = rv; v.accept = acc; v.rdValid = dv; v.rdData = d; v.flags = fl;
        v.datWe = dwe; v.datAddr = da; v.datData = dd; v.dreWe = rwe; v.dreAddr = ra; v.dreRe = re;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idleInputs();
        req_valid = 1'b0; mem_readAccept = 1'b0; mem_readDataValid = 1'b0; mem_readData = '0;
    endtask

    // Drives one request at line 3 / channel 2 and a memory with programmable accept delay
    // and inter-beat gap; records every write until done or a cycle budget runs out.
    task automatic runFill(input int accDelay, input int gap, input logic [2:0] off);
        int cyc = 0;
        int reqSeen = 0;
        int beat = 0;
        int gapCnt = 0;
        datQ.delete(); dreQ.delete(); reqCycles = 0; doneCnt = 0;
        @(negedge clk);
        req_valid = 1'b1; req_lineAddr = 5'd3; req_channel = 2'd2; req_wordOffset = off;
        @(negedge clk);
        req_valid = 1'b0;
        while (cyc < 200 && doneCnt == 0) begin
            mem_readAccept = 1'b0; mem_readDataValid = 1'b0;
            if (mem_readRequest) begin
                if (reqSeen == accDelay) mem_readAccept = 1'b1;
                reqSeen++; reqCycles++;
            end else if (reqSeen > 0 && beat < 8) begin
                if (gapCnt == 0) begin
                    mem_readDataValid = 1'b1; mem_readData = 32'h11 * (beat + 1);
                    beat++; gapCnt = gap;
                end else gapCnt--;
            end
            #1;
            if (dat_writeEnable) datQ.push_back({dat_writeAddress, dat_writeData});
            if (dre_writeEnable) dreQ.push_back({8'(datQ.size()), dre_writeAddress, dre_writeRe});
            if (done) doneCnt++;
            @(negedge clk);
            cyc++;
        end
        idleInputs();
        if (cyc >= 200) check("fillTimeout", 128'(cyc), 128'(0));
    endtask

    task automatic checkFill(input string tag, input logic [2:0] off, input logic [23:0] expFF[4]);
        check({tag, "_datCount"}, 128'(datQ.size()), 128'(8));
        for (int k = 0; k < 8 && k < datQ.size(); k++)
            check({tag, "_dat"}, 128'(datQ[k]), 128'({8'h18 + 8'((int'(off) + k) % 8), 32'h11 * (k + 1)}));
        check({tag, "_dreCount"}, 128'(dreQ.size()), 128'(8));
        for (int p = 0; p < 4 && p < dreQ.size(); p++)
            check({tag, "_dreClear"}, 128'(dreQ[p]), 128'({8'd0, 8'h18 + 8'(2 * p), 8'h00}));
        for (int p = 0; p < 4 && p + 4 < dreQ.size(); p++)
            check({tag, "_dreSet"}, 128'(dreQ[p + 4]), 128'(expFF[p]));
        check({tag, "_doneCount"}, 128'(doneCnt), 128'(1));
    endtask

    initial begin
        logic [127:0] act;
        logic [127:0] exp;
        logic [23:0]  ffSeq[4];
        int           stray;

        rst = 1'b1; req_lineAddr = 5'd3; req_channel = 2'd2; req_wordOffset = 3'd0;
        idleInputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("resetState", 128'({req_ready, busy, done, mem_readRequest, dat_writeEnable, dre_writeEnable}),
              128'(6'b100000));
        rst = 1'b0;

        // Zero-wait fill of line 3, channel 2; a second request during CLEAR, a 9th beat
        // during DONE and a stray beat in IDLE must all be ignored.
        vt.push_back(mk(1, 0, 0, 0, 4'b1000, 0, 0, 0, 0, 0, 0));
        for (int c = 0; c < 4; c++)
            vt.push_back(mk(c == 1, 0, 0, 0, 4'b0100, 0, 0, 0, 1, 8'h18 + 8'(2 * c), 8'h00));
        vt.push_back(mk(0, 1, 0, 0, 4'b0101, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 8; k++)
            vt.push_back(mk(0, 0, 1, 32'h11 * (k + 1), 4'b0100, 1, 8'h18 + 8'(k), 32'h11 * (k + 1),
                            k % 2 == 1, 8'h18 + 8'(k - (k % 2)), 8'hFF));
        vt.push_back(mk(0, 0, 1, 32'h99, 4'b0110, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 32'hAA, 4'b1000, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 4'b1000, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            req_valid = vt[i].reqValid; mem_readAccept = vt[i].accept;
            mem_readDataValid = vt[i].rdValid; mem_readData = vt[i].rdData;
            #1;
            exp = {4'b0, vt[i].flags, vt[i].flags[0] ? 8'h18 : 8'h00,
                   vt[i].datWe, vt[i].datWe ? {vt[i].datAddr, 2'd2, vt[i].datData} : 42'd0,
                   vt[i].dreWe, vt[i].dreWe ? {vt[i].dreAddr, 2'd2, vt[i].dreRe} : 18'd0};
            act = {4'b0, req_ready, busy, done, mem_readRequest, vt[i].flags[0] ? mem_address : 8'h00,
                   dat_writeEnable, vt[i].datWe ? {dat_writeAddress, dat_writeChannel, dat_writeData} : 42'd0,
                   dre_writeEnable, vt[i].dreWe ? {dre_writeAddress, dre_writeChannel, dre_writeRe} : 18'd0};
            check($sformatf("vec%0d", i), act, exp);
        end
        idleInputs();

        // Accept held off for 5 cycles, beats arriving every third cycle.
        for (int p = 0; p < 4; p++) ffSeq[p] = {8'(2 * p + 2), 8'h18 + 8'(2 * p), 8'hFF};
        runFill(5, 2, 3'd0);
        check("reqHeldCycles", 128'(reqCycles), 128'(6));
        checkFill("gapped", 3'd0, ffSeq);

        // Reset held two cycles after the third beat of a fill.
        @(negedge clk);
        req_valid = 1'b1; req_wordOffset = 3'd0;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 0; c < 20 && !mem_readRequest; c++) @(negedge clk);
        check("rstReachReq", 128'(mem_readRequest), 128'(1));
        mem_readAccept = 1'b1;
        @(negedge clk);
        mem_readAccept = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mem_readDataValid = 1'b1; mem_readData = 32'h5A5A_0000 + 32'(k);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        check("rstFirstEdge", 128'({req_ready, busy, done, mem_readRequest, dat_writeEnable, dre_writeEnable}),
              128'(6'b100000));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstReleased", 128'({req_ready, busy, done, mem_readRequest, dat_writeEnable, dre_writeEnable}),
              128'(6'b100000));
        stray = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            #1;
            if (done || busy || dat_writeEnable || dre_writeEnable) stray++;
        end
        idleInputs();
        check("rstNoDoneNoActivity", 128'(stray), 128'(0));

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        // Start at word 5: pairs 6,0,2 complete on beats 3,5,7 and pair 4 on the last beat.
        ffSeq[0] = {8'd3, 8'h1E, 8'hFF};
        ffSeq[1] = {8'd5, 8'h18, 8'hFF};
        ffSeq[2] = {8'd7, 8'h1A, 8'hFF};
        ffSeq[3] = {8'd8, 8'h1C, 8'hFF};
        @(negedge clk);
        req_lineAddr = 5'd3; req_wordOffset = 3'd5; #1;
        runFill(0, 0, 3'd5);
        check("cwfReqCycles", 128'(reqCycles), 128'(1));
        checkFill("cwf", 3'd5, ffSeq);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
